fft_bit_reverse_reorder: RTL and testbench
==========================================

# fft_bit_reverse_reorder

Output reorder stage for the radix-2² SDF FFT pipeline. Sits directly downstream of the FFT top and consumes its bit-reversed output stream (`odata_en`/`odata_r`/`odata_i`). Buffers each complete N-sample frame in a ping-pong RAM and re-emits it in natural frequency order, with a per-sample bin index. Purely a data-movement block: no arithmetic on sample values.

## Interface
- `N`, 128, FFT length; power of two, 4..1024.
- `WIDTH`, 16, data word length (real and imag each).
- `LOG_N`, log2(N), derived localparam, not overridable.

- `clock`  in  1  master clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `idata_en`  in  1  input sample valid; one sample per high cycle.
- `idata_r`  in  WIDTH  input real, bit-reversed order.
- `idata_i`  in  WIDTH  input imag, bit-reversed order.
- `odata_en`  out  1  output sample valid.
- `odata_r`  out  WIDTH  output real, natural order.
- `odata_i`  out  WIDTH  output imag, natural order.
- `odata_idx`  out  LOG_N  bin index k of current output sample.

## Operation
- Storage: 2 banks × N words × 2·WIDTH bits, single write port, single registered read port; contents never reset.
- Write side: counter `wcnt` (LOG_N bits) and bank select `wbank`.
  - Each cycle with `idata_en`=1: write {idata_r, idata_i} to bank `wbank` at address bitrev(`wcnt`); `wcnt` += 1.
  - When the sample written has `wcnt` = N-1: `wcnt` wraps to 0, `wbank` toggles, pulse `frame_done` (internal, 1 cycle).
  - `idata_en` may be gapped arbitrarily; only valid cycles count.
- Read side FSM, states IDLE and READ; counter `rcnt` (LOG_N bits), bank `rbank`.
  - IDLE: on `frame_done`, `rbank` ← bank just filled, `rcnt` ← 0, go READ.
  - READ: issue read of bank `rbank` at address `rcnt` each cycle; `rcnt` += 1. At `rcnt` = N-1: if `frame_done` same cycle, `rbank` toggles, `rcnt` ← 0, stay READ (back-to-back); else go IDLE.
  - `frame_done` while in READ with `rcnt` ≠ N-1 cannot occur (input rate ≤ 1 sample/cycle guarantees it); a bench assertion flags it.
- Output register: one cycle after a read is issued, `odata_en`=1, `odata_r`/`odata_i` = RAM data, `odata_idx` = `rcnt` of issuing cycle. Cycles with no read issued: `odata_en`=0, data and idx hold last value.
- Bit reversal: bitrev(a)[b] = a[LOG_N-1-b], pure wiring.

## Timing
- Reset (synchronous): next edge sets `odata_en`=0, `odata_r`=0, `odata_i`=0, `odata_idx`=0, `wcnt`=0, `rcnt`=0, `wbank`=0, `rbank`=0, FSM=IDLE.
- Reset mid-write: partial frame discarded; next valid input is sample 0 of bank 0.
- Reset mid-read: output stops; `odata_en` low from the cycle after the reset edge; the interrupted frame is not resumed.
- Latency: last sample of a frame accepted at cycle t → first read issued t+1 → `odata_en` high cycles t+2..t+N+1, contiguous, `odata_idx` 0..N-1.
- Back-to-back contiguous input frames produce contiguous output with no idle cycle between frames.
- Throughput: 1 sample/cycle sustained; no backpressure port.
- Simultaneous write and read of same address never occur (always opposite banks).

## Test plan
- Single frame, N=128, contiguous: input arrival position p carries value r=p, i=-p → output cycle k has `odata_idx`=k, r=bitrev7(k), i=-bitrev7(k); e.g. k=1 → r=64; `odata_en` high exactly 128 cycles starting 2 cycles after last input.
- Four contiguous frames (512 cycles `idata_en`=1): output `odata_en` continuously high for 512 cycles, frame f values offset by 1000·f, order correct per frame.
- Gapped input: `idata_en` toggles 1,0,1,0 for one frame → output still one contiguous 128-cycle burst, starting 2 cycles after the 128th valid sample.
- Reset asserted after 50 input samples, then a full clean frame → only the clean frame is output, values correct, bank 0 used.
- Reset asserted at output index 30 → `odata_en`=0, data 0 from next cycle; subsequent frame outputs fully and correctly.
- N=8 build: input values 0..7 → output sequence 0,4,2,6,1,5,3,7 with `odata_idx` 0..7.

Source files
------------

// File: rtl/fft_bit_reverse_reorder_if.sv
`default_nettype none
// ============================================================================
// Module      : fft_bit_reverse_reorder_if
// Description : Sample stream bundle for the FFT output reorder stage:
//               bit-reversed input samples and natural-order output samples
//               tagged with their bin index.
// Revision    : 1.0 - initial release
// ============================================================================
interface fft_bit_reverse_reorder_if #(
  parameter int WIDTH = 16,
  parameter int LOG_N = 7
);
  logic             idata_en;
  logic [WIDTH-1:0] idata_r;
  logic [WIDTH-1:0] idata_i;
  logic             odata_en;
  logic [WIDTH-1:0] odata_r;
  logic [WIDTH-1:0] odata_i;
  logic [LOG_N-1:0] odata_idx;

  // Producer/consumer side: drives input samples, observes reordered output.
  modport master (
    output idata_en, idata_r, idata_i,
    input  odata_en, odata_r, odata_i, odata_idx
  );

  // Reorder block side.
  modport slave (
    input  idata_en, idata_r, idata_i,
    output odata_en, odata_r, odata_i, odata_idx
  );
endinterface
`default_nettype wire

// File: rtl/fft_bit_reverse_reorder.sv
`default_nettype none
// ============================================================================
// Module      : fft_bit_reverse_reorder
// Description : Ping-pong frame buffer that turns the bit-reversed FFT output
//               stream into natural frequency order. Samples are written at
//               the bit-reversed address of their arrival position and read
//               back linearly, one sample per cycle, with the bin index.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_bit_reverse_reorder #(
  parameter int N     = 128,
  parameter int WIDTH = 16
) (
  input wire clock,
  input wire reset,
  fft_bit_reverse_reorder_if.slave bus
);

  localparam int              LOG_N = $clog2(N);
  localparam int              DW    = 2 * WIDTH;
  localparam logic [LOG_N-1:0] LAST = LOG_N'(N - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_READ = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Write side: arrival counter, bank select and frame completion
  // --------------------------------------------------------------------------
  logic [LOG_N-1:0] wcnt_q, wcnt_d;
  logic             wbank_q, wbank_d;
  logic             frame_done;
  logic [LOG_N-1:0] waddr;

  // Bit reversal of the arrival position is pure wiring.
  for (genvar b = 0; b < LOG_N; b++) begin : g_bitrev
    assign waddr[b] = wcnt_q[LOG_N-1-b];
  end

  // Advance the arrival counter on valid samples; the last sample of a frame
  // flips the bank and signals the read side in the same cycle.
  always_comb begin
    wcnt_d     = wcnt_q;
    wbank_d    = wbank_q;
    frame_done = 1'b0;
    if (bus.idata_en) begin
      wcnt_d = wcnt_q + 1'b1;  // N is a power of two, so this wraps at N-1
      if (wcnt_q == LAST) begin
        wbank_d    = ~wbank_q;
        frame_done = 1'b1;
      end
    end
  end

  // Write-side state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wcnt_q  <= '0;
      wbank_q <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      wbank_q <= wbank_d;
    end
  end

  // --------------------------------------------------------------------------
  // Frame storage: two banks, bank select is the address MSB. Never reset.
  // --------------------------------------------------------------------------
  logic [DW-1:0] mem [0:2*N-1];

  // Single write port.
  always_ff @(posedge clock) begin
    if (bus.idata_en) begin
      mem[{wbank_q, waddr}] <= {bus.idata_r, bus.idata_i};
    end
  end

  // --------------------------------------------------------------------------
  // Read side FSM: linear scan of the bank that was just filled
  // --------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [LOG_N-1:0] rcnt_q, rcnt_d;
  logic             rbank_q, rbank_d;
  logic             rd_issue;

  // Next-state logic. A new frame can only complete while reading the last
  // address of the previous one, which is where back-to-back frames chain.
  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    rbank_d  = rbank_q;
    rd_issue = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_done) begin
          rbank_d = wbank_q;
          rcnt_d  = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        rd_issue = 1'b1;
        rcnt_d   = rcnt_q + 1'b1;
        if (rcnt_q == LAST) begin
          if (frame_done) begin
            rbank_d = ~rbank_q;
            rcnt_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read-side FSM registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      rcnt_q  <= '0;
      rbank_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      rbank_q <= rbank_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output register: doubles as the RAM's registered read port. Data and
  // index hold their last value on cycles without a read.
  // --------------------------------------------------------------------------
  logic             odata_en_q;
  logic [WIDTH-1:0] odata_r_q, odata_i_q;
  logic [LOG_N-1:0] odata_idx_q;

  // Capture RAM data and bin index one cycle after each read is issued.
  always_ff @(posedge clock) begin
    if (reset) begin
      odata_en_q  <= 1'b0;
      odata_r_q   <= '0;
      odata_i_q   <= '0;
      odata_idx_q <= '0;
    end else begin
      odata_en_q <= rd_issue;
      if (rd_issue) begin
        {odata_r_q, odata_i_q} <= mem[{rbank_q, rcnt_q}];
        odata_idx_q            <= rcnt_q;
      end
    end
  end

  assign bus.odata_en  = odata_en_q;
  assign bus.odata_r   = odata_r_q;
  assign bus.odata_i   = odata_i_q;
  assign bus.odata_idx = odata_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_bit_reverse_reorder.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_bit_reverse_reorder
// Description : Directed bench for the FFT output reorder stage (N=128 and
//               N=8 builds): table of hand-computed output samples plus
//               stream checks for timing, contiguity and reset behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_bit_reverse_reorder;

  localparam int N   = 128;
  localparam int LN  = 7;
  localparam int N8  = 8;
  localparam int LN8 = 3;
  localparam int W   = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fft_bit_reverse_reorder_if #(.WIDTH(W), .LOG_N(LN))  bus  ();
  fft_bit_reverse_reorder_if #(.WIDTH(W), .LOG_N(LN8)) bus8 ();

  fft_bit_reverse_reorder #(.N(N),  .WIDTH(W)) dut  (.clock(clock), .reset(reset), .bus(bus));
  fft_bit_reverse_reorder #(.N(N8), .WIDTH(W)) dut8 (.clock(clock), .reset(reset), .bus(bus8));

  typedef struct {
    int tst;
    int j;
    int exp_r;
    int exp_i;
    int exp_idx;
  } vec_t;

  typedef struct {
    int r;
    int i;
    int idx;
    int edge_n;
  } cap_t;

  vec_t tbl[$];
  cap_t q[$];
  cap_t q8[$];

  int vectors     = 0;
  int miscompares = 0;
  int ecnt        = 0;
  int last_acc    = 0;
  int last_acc8   = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int brev(input int k, input int bits);
    int r = 0;
    for (int b = 0; b < bits; b++) if (k[b]) r |= (1 << (bits - 1 - b));
    return r;
  endfunction

  // One clock: check the in-band assertion with current inputs, cross the
  // active edge, then sample both outputs on the falling edge.
  task automatic step();
    #1;
    if (!reset && dut.frame_done && dut.rd_issue && dut.rcnt_q != 7'd127) begin
      miscompares++;
      $display("FAIL frame_done_mid_read: rcnt %0d, required 127", dut.rcnt_q);
    end
    @(posedge clock);
    ecnt++;
    @(negedge clock);
    if (bus.odata_en)
      q.push_back('{int'($signed(bus.odata_r)), int'($signed(bus.odata_i)),
                    int'(bus.odata_idx), ecnt});
    if (bus8.odata_en)
      q8.push_back('{int'($signed(bus8.odata_r)), int'($signed(bus8.odata_i)),
                     int'(bus8.odata_idx), ecnt});
  endtask

  task automatic send(input int r, input int i, input bit en);
    bus.idata_en = en;
    bus.idata_r  = W'(r);
    bus.idata_i  = W'(i);
    step();
    if (en) last_acc = ecnt;
  endtask

  task automatic send8(input int r, input int i, input bit en);
    bus8.idata_en = en;
    bus8.idata_r  = W'(r);
    bus8.idata_i  = W'(i);
    step();
    if (en) last_acc8 = ecnt;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) send(0, 0, 1'b0);
  endtask

  // Whole-stream check: count, contiguous timing, index and values.
  task automatic check_stream(input bit use8, input int count, input int first_edge,
                              input int mult, input int offset, input int nn, input int bits);
    int sz;
    sz = use8 ? q8.size() : q.size();
    chk("stream_len", sz, count);
    for (int j = 0; j < count && j < sz; j++) begin
      cap_t c;
      int f, k, er;
      c  = use8 ? q8[j] : q[j];
      f  = j / nn;
      k  = j % nn;
      er = offset + mult * f + brev(k, bits);
      chk($sformatf("edge[%0d]", j), c.edge_n, first_edge + j);
      chk($sformatf("idx[%0d]", j), c.idx, k);
      chk($sformatf("re[%0d]", j), c.r, er);
      chk($sformatf("im[%0d]", j), c.i, -er);
    end
  endtask

  task automatic check_table(input int tst, input bit use8);
    for (int n = 0; n < tbl.size(); n++) begin
      if (tbl[n].tst == tst) begin
        int sz;
        cap_t c;
        sz = use8 ? q8.size() : q.size();
        if (tbl[n].j >= sz) begin
          vectors++;
          miscompares++;
          $display("FAIL tbl%0d[%0d]: no output sample, required re %0d", tst, tbl[n].j, tbl[n].exp_r);
        end else begin
          c = use8 ? q8[tbl[n].j] : q[tbl[n].j];
          chk($sformatf("tbl%0d[%0d].idx", tst, tbl[n].j), c.idx, tbl[n].exp_idx);
          chk($sformatf("tbl%0d[%0d].re",  tst, tbl[n].j), c.r,   tbl[n].exp_r);
          chk($sformatf("tbl%0d[%0d].im",  tst, tbl[n].j), c.i,   tbl[n].exp_i);
        end
      end
    end
  endtask

  initial begin
    int first_last;
    bit found;

    // Hand-computed expected samples {test, output position, re, im, idx}.
    // 1: single frame, value p
    tbl.push_back('{1,   0,   0,    0,   0});
    tbl.push_back('{1,   1,  64,  -64,   1});
    tbl.push_back('{1,   2,  32,  -32,   2});
    tbl.push_back('{1,   3,  96,  -96,   3});
    tbl.push_back('{1,   5,  80,  -80,   5});
    tbl.push_back('{1,  64,   1,   -1,  64});
    tbl.push_back('{1, 100,  19,  -19, 100});
    tbl.push_back('{1, 127, 127, -127, 127});
    // 2: clean frame after mid-write reset, value 300+p
    tbl.push_back('{2,   1, 364, -364,   1});
    tbl.push_back('{2, 126, 363, -363, 126});
    // 3: gapped input, value 700+p
    tbl.push_back('{3,   1, 764, -764,   1});
    tbl.push_back('{3,   6, 748, -748,   6});
    // 4: four back-to-back frames, value 1000f+p
    tbl.push_back('{4,   0,    0,     0,   0});
    tbl.push_back('{4, 128, 1000, -1000,   0});
    tbl.push_back('{4, 129, 1064, -1064,   1});
    tbl.push_back('{4, 255, 1127, -1127, 127});
    tbl.push_back('{4, 389, 3080, -3080,   5});
    tbl.push_back('{4, 511, 3127, -3127, 127});
    // 5: frame after mid-read reset, value 2000+p
    tbl.push_back('{5,   2, 2032, -2032,   2});
    tbl.push_back('{5, 127, 2127, -2127, 127});
    // 6: N=8 build, value p
    tbl.push_back('{6, 0, 0,  0, 0});
    tbl.push_back('{6, 1, 4, -4, 1});
    tbl.push_back('{6, 2, 2, -2, 2});
    tbl.push_back('{6, 3, 6, -6, 3});
    tbl.push_back('{6, 4, 1, -1, 4});
    tbl.push_back('{6, 5, 5, -5, 5});
    tbl.push_back('{6, 6, 3, -3, 6});
    tbl.push_back('{6, 7, 7, -7, 7});

    bus.idata_en  = 1'b0; bus.idata_r  = '0; bus.idata_i  = '0;
    bus8.idata_en = 1'b0; bus8.idata_r = '0; bus8.idata_i = '0;
    reset = 1'b1;
    @(negedge clock);
    for (int c = 0; c < 3; c++) step();
    chk("rst_en",   int'(bus.odata_en), 0);
    chk("rst_re",   int'(bus.odata_r), 0);
    chk("rst_im",   int'(bus.odata_i), 0);
    chk("rst_idx",  int'(bus.odata_idx), 0);
    chk("rst8_en",  int'(bus8.odata_en), 0);
    reset = 1'b0;
    idle(2);

    // Single contiguous frame.
    q.delete();
    for (int p = 0; p < N; p++) send(p, -p, 1'b1);
    idle(140);
    check_stream(1'b0, N, last_acc + 1, 0, 0, N, LN);
    check_table(1, 1'b0);

    // Reset after 50 samples of a partial frame, then a clean frame.
    q.delete();
    for (int p = 0; p < 50; p++) send(500 + p, -(500 + p), 1'b1);
    reset = 1'b1;
    send(0, 0, 1'b0);
    reset = 1'b0;
    idle(2);
    for (int p = 0; p < N; p++) send(300 + p, -(300 + p), 1'b1);
    idle(140);
    check_stream(1'b0, N, last_acc + 1, 0, 300, N, LN);
    check_table(2, 1'b0);
    chk("t4_rbank", int'(dut.rbank_q), 0);
    chk("t4_wbank", int'(dut.wbank_q), 1);

    // Gapped input 1,0,1,0...
    q.delete();
    for (int p = 0; p < N; p++) begin
      send(700 + p, -(700 + p), 1'b1);
      send(0, 0, 1'b0);
    end
    idle(140);
    check_stream(1'b0, N, last_acc + 1, 0, 700, N, LN);
    check_table(3, 1'b0);

    // Four back-to-back frames.
    q.delete();
    first_last = 0;
    for (int f = 0; f < 4; f++) begin
      for (int p = 0; p < N; p++) begin
        send(1000 * f + p, -(1000 * f + p), 1'b1);
        if (f == 0 && p == N - 1) first_last = last_acc;
      end
    end
    idle(140);
    check_stream(1'b0, 4 * N, first_last + 1, 1000, 0, N, LN);
    check_table(4, 1'b0);

    // Reset while output index 30 is on the port.
    q.delete();
    for (int p = 0; p < N; p++) send(1500 + p, -(1500 + p), 1'b1);
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      send(0, 0, 1'b0);
      if (bus.odata_en && bus.odata_idx == 7'd30) found = 1'b1;
    end
    chk("t5_found_idx30", int'(found), 1);
    chk("t5_re_idx30", int'($signed(bus.odata_r)), 1560);
    reset = 1'b1;
    send(0, 0, 1'b0);
    chk("t5_rst_en",  int'(bus.odata_en), 0);
    chk("t5_rst_re",  int'(bus.odata_r), 0);
    chk("t5_rst_im",  int'(bus.odata_i), 0);
    chk("t5_rst_idx", int'(bus.odata_idx), 0);
    reset = 1'b0;
    q.delete();
    idle(150);
    chk("t5_no_resume", q.size(), 0);
    for (int p = 0; p < N; p++) send(2000 + p, -(2000 + p), 1'b1);
    idle(140);
    check_stream(1'b0, N, last_acc + 1, 0, 2000, N, LN);
    check_table(5, 1'b0);

    // N=8 build.
    q8.delete();
    for (int p = 0; p < N8; p++) send8(p, -p, 1'b1);
    send8(0, 0, 1'b0);
    for (int c = 0; c < 20; c++) step();
    check_stream(1'b1, N8, last_acc8 + 1, 0, 0, N8, LN8);
    check_table(6, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
